// File: rtl/usr_irq_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | usr_irq_slave                                                              |
// | Avalon-MM slave turning user IRQ writes into a latched, maskable irq line. |
// | Optional: USR_IRQ_SLAVE_EVT_CNT_EN builds the EVT_CNT event counter.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module usr_irq_slave #(
  parameter int N_SRC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        irq_avalon_slave_chipselect,
  input  logic [3:0]  irq_avalon_slave_address,
  input  logic        irq_avalon_slave_read,
  input  logic        irq_avalon_slave_write,
  input  logic [31:0] irq_avalon_slave_writedata,
  output logic        irq_avalon_slave_waitrequest,
  output logic [31:0] irq_avalon_slave_readdata,
  output logic        irq
);

  localparam logic [3:0] c_ADDR_LEVEL   = 4'h0;
  localparam logic [3:0] c_ADDR_PENDING = 4'h1;
  localparam logic [3:0] c_ADDR_MASK    = 4'h2;
  localparam logic [3:0] c_ADDR_EVT_CNT = 4'h3;

  logic [N_SRC-1:0] r_level;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_mask;
  logic             r_irq;
  logic             r_rd_ack;
  logic [31:0]      r_readdata;

  logic             w_wr;
  logic             w_rd;
  logic             w_rd_t0;
  logic             w_wr_level;
  logic             w_wr_pending;
  logic             w_wr_mask;
  logic [N_SRC-1:0] w_wdata;
  logic [N_SRC-1:0] w_level_next;
  logic [N_SRC-1:0] w_set;
  logic [N_SRC-1:0] w_w1c;
  logic [N_SRC-1:0] w_pending_next;
  logic [31:0]      w_evt_cnt_rd;
  logic [31:0]      w_rd_mux;
  logic             w_unused;

  // A simultaneous read and write is treated as a write only.
  assign w_wr    = irq_avalon_slave_chipselect & irq_avalon_slave_write;
  assign w_rd    = irq_avalon_slave_chipselect & irq_avalon_slave_read & ~irq_avalon_slave_write;
  assign w_rd_t0 = w_rd & ~r_rd_ack;

  assign w_wdata      = irq_avalon_slave_writedata[N_SRC-1:0];
  assign w_wr_level   = w_wr & (irq_avalon_slave_address == c_ADDR_LEVEL);
  assign w_wr_pending = w_wr & (irq_avalon_slave_address == c_ADDR_PENDING);
  assign w_wr_mask    = w_wr & (irq_avalon_slave_address == c_ADDR_MASK);
  assign w_unused     = ^irq_avalon_slave_writedata;

  assign w_level_next   = w_wr_level ? w_wdata : r_level;
  assign w_set          = ~r_level & w_level_next;
  assign w_w1c          = w_wr_pending ? w_wdata : '0;
  // Set has priority over a same-cycle W1C of the same bit.
  assign w_pending_next = (r_pending & ~w_w1c) | w_set;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_level   <= '0;
      r_pending <= '0;
      r_mask    <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_level   <= w_level_next;
      r_pending <= w_pending_next;
      if (w_wr_mask) begin
        r_mask <= w_wdata;
      end
      r_irq     <= |(r_pending & r_mask);
    end
  end

`ifdef USR_IRQ_SLAVE_EVT_CNT_EN
  logic [15:0] r_evt_cnt;
  logic [5:0]  w_set_cnt;
  logic [16:0] w_cnt_sum;
  logic        w_wr_evt_cnt;

  assign w_wr_evt_cnt = w_wr & (irq_avalon_slave_address == c_ADDR_EVT_CNT);

  always_comb begin
    w_set_cnt = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_set_cnt = w_set_cnt + 6'(w_set[i]);
    end
  end

  // Clearing and counting in the same cycle leaves just the new events.
  assign w_cnt_sum = (w_wr_evt_cnt ? 17'd0 : {1'b0, r_evt_cnt}) + 17'(w_set_cnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_evt_cnt <= '0;
    end else begin
      r_evt_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end
  end

  assign w_evt_cnt_rd = {16'd0, r_evt_cnt};
`else
  assign w_evt_cnt_rd = '0;
`endif

  always_comb begin
    w_rd_mux = '0;
    case (irq_avalon_slave_address)
      c_ADDR_LEVEL:   w_rd_mux[N_SRC-1:0] = r_level;
      c_ADDR_PENDING: w_rd_mux[N_SRC-1:0] = r_pending;
      c_ADDR_MASK:    w_rd_mux[N_SRC-1:0] = r_mask;
      c_ADDR_EVT_CNT: w_rd_mux            = w_evt_cnt_rd;
      default:        w_rd_mux            = '0;
    endcase
  end

  // Data is captured at the end of the wait cycle; the ack opens the completion cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ack   <= 1'b0;
      r_readdata <= '0;
    end else begin
      r_rd_ack <= w_rd_t0;
      if (w_rd_t0) begin
        r_readdata <= w_rd_mux;
      end
    end
  end

  assign irq_avalon_slave_waitrequest = w_rd_t0;
  assign irq_avalon_slave_readdata    = r_readdata;
  assign irq                          = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_usr_irq_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_usr_irq_slave                                                           |
// | Scoreboard bench for usr_irq_slave; honours USR_IRQ_SLAVE_EVT_CNT_EN.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_usr_irq_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs;
  logic [3:0]  addr;
  logic        read;
  logic        write;
  logic [31:0] wdata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_errs   = 0;

  string       qn[$];
  logic [31:0] qe[$];

  usr_irq_slave #(.N_SRC(4)) dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .irq_avalon_slave_chipselect  (cs),
    .irq_avalon_slave_address     (addr),
    .irq_avalon_slave_read        (read),
    .irq_avalon_slave_write       (write),
    .irq_avalon_slave_writedata   (wdata),
    .irq_avalon_slave_waitrequest (waitrequest),
    .irq_avalon_slave_readdata    (readdata),
    .irq                          (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Read completions are matched in order against the expected-data queue.
  always @(negedge clk) begin
    if (cs && read && !write && !waitrequest) begin
      if (qe.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_read: got 0x%08h expected no completion", readdata);
      end else begin
        string       nm;
        logic [31:0] e;
        nm = qn.pop_front();
        e  = qe.pop_front();
        check(nm, readdata, e);
      end
    end
  end

  // All tasks start and end one time unit after a rising edge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; read = 1'b0; addr = a; wdata = d;
    @(posedge clk); #1;
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic rd_wait(input string nm);
    int ws;
    ws = 0;
    @(negedge clk);
    while (waitrequest && ws < 8) begin
      ws++;
      @(negedge clk);
    end
    check({nm, "_waitstates"}, 32'(ws), 32'd1);
    @(posedge clk); #1;
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string nm);
    qn.push_back(nm);
    qe.push_back(exp);
    cs = 1'b1; read = 1'b1; write = 1'b0; addr = a;
    rd_wait(nm);
  endtask

  task automatic chk_irq(input logic exp, input string nm);
    @(posedge clk); #1;
    check(nm, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_waitrequest", {31'd0, waitrequest}, 32'd0);
    rst_n = 1'b1;
    rd(4'h0, 32'h0, "rst_level");
    rd(4'h1, 32'h0, "rst_pending");
    rd(4'h2, 32'h0, "rst_mask");
    rd(4'h3, 32'h0, "rst_evt_cnt");
    rd(4'h5, 32'h0, "unmapped");

    // Edge detect and masking
    wr(4'h2, 32'h1);
    wr(4'h0, 32'h1);
    chk_irq(1'b1, "irq_after_rise");
    rd(4'h1, 32'h1, "pend_rise");
    rd(4'h0, 32'h1, "level_rb");
    wr(4'h0, 32'h0);
    chk_irq(1'b1, "irq_after_fall");
    rd(4'h1, 32'h1, "pend_after_fall");
    wr(4'h1, 32'h1);
    chk_irq(1'b0, "irq_after_w1c");
    rd(4'h1, 32'h0, "pend_after_w1c");

    // Masked source
    wr(4'h2, 32'h0);
    wr(4'h0, 32'h2);
    chk_irq(1'b0, "irq_masked");
    rd(4'h1, 32'h2, "pend_masked");
    wr(4'h2, 32'h2);
    chk_irq(1'b1, "irq_unmasked");

    // W1C one cycle before a fresh rise: the rise sets the bit again
    wr(4'h0, 32'h1);
    wr(4'h0, 32'h0);
    wr(4'h1, 32'h1);
    wr(4'h0, 32'h1);
    rd(4'h1, 32'h3, "pend_w1c_then_set");
    wr(4'h0, 32'h1);
    rd(4'h1, 32'h3, "pend_no_reset_on_hold");

`ifdef USR_IRQ_SLAVE_EVT_CNT_EN
    wr(4'h3, 32'h0);
    rd(4'h3, 32'h0, "evt_clear");
    wr(4'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      wr(4'h0, 32'h1);
      wr(4'h0, 32'h0);
    end
    wr(4'h0, 32'hF);
    rd(4'h3, 32'h7, "evt_cnt7");
    wr(4'h3, 32'h1234);
    rd(4'h3, 32'h0, "evt_clear2");
    wr(4'h0, 32'h0);
    for (int i = 0; i < 16383; i++) begin
      wr(4'h0, 32'hF);
      wr(4'h0, 32'h0);
    end
    wr(4'h0, 32'h3);
    wr(4'h0, 32'h0);
    rd(4'h3, 32'hFFFE, "evt_preload");
    wr(4'h0, 32'h3);
    rd(4'h3, 32'hFFFF, "evt_saturate");
    wr(4'h0, 32'h0);
    wr(4'h0, 32'h1);
    rd(4'h3, 32'hFFFF, "evt_sat_hold");
`else
    wr(4'h0, 32'h0);
    wr(4'h0, 32'hF);
    rd(4'h3, 32'h0, "evt_absent");
    wr(4'h3, 32'hFFFF);
    rd(4'h3, 32'h0, "evt_absent_wr");
`endif

    // Unimplemented bits, back-to-back reads, read+write together
    wr(4'h2, 32'hFFFF_FFFF);
    rd(4'h2, 32'hF, "mask_upper_zero");
    rd(4'h2, 32'hF, "b2b_first");
    rd(4'h2, 32'hF, "b2b_second");
    cs = 1'b1; read = 1'b1; write = 1'b1; addr = 4'h2; wdata = 32'h5;
    @(negedge clk);
    check("rdwr_no_wait", {31'd0, waitrequest}, 32'd0);
    @(posedge clk); #1;
    cs = 1'b0; read = 1'b0; write = 1'b0;
    rd(4'h2, 32'h5, "rdwr_write_done");

    // Reset during the wait cycle, read held throughout
    cs = 1'b1; read = 1'b1; write = 1'b0; addr = 4'h2; rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_mid_waitrequest", {31'd0, waitrequest}, 32'd1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    qn.push_back("rst_mid_restart");
    qe.push_back(32'h0);
    rd_wait("rst_mid_restart");
    check("rst_mid_irq", {31'd0, irq}, 32'd0);

    repeat (3) @(posedge clk);
    check("sb_drain", 32'(qe.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
